// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per cycle, with a registered result and destination index for writeback.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0]   ONE    = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE2   = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]   MIN_SV = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic [4:0]      rd_cap_q, rd_cap_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [XLEN-1:0] acc_q, acc_d;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;       // multiplier bits / dividend-then-quotient
    logic [XLEN-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude

    // Capture-side decode straight from the register file operands.
    logic            a_signed, b_signed, sa_in, sb_in, in_div0, in_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign sa_in    = a_signed & a[XLEN-1];
    assign sb_in    = b_signed & b[XLEN-1];
    assign mag_a    = sa_in ? (~a + ONE) : a;
    assign mag_b    = sb_in ? (~b + ONE) : b;
    assign in_div0  = op[2] && (b == '0);
    assign in_ovf   = op[2] && !op[0] && (a == MIN_SV) && (b == '1);
    // Overflow quotient equals the dividend itself (0x80000000).
    assign special_res = in_div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    // One multiply step: conditional add, then shift the 2*XLEN product right.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_acc, mul_lo;
    assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign {mul_acc, mul_lo} = {mul_sum, lo_q[XLEN-1:1]};

    // One restoring-divide step on {rem, quo} shifted left.
    logic [XLEN:0]   div_sh, div_diff;
    logic            div_ok;
    logic [XLEN-1:0] div_acc, div_lo;
    assign div_sh   = {acc_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_ok   = !div_diff[XLEN];
    assign div_acc  = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    assign div_lo   = {lo_q[XLEN-2:0], div_ok};

    logic [XLEN-1:0]   step_acc, step_lo, quo_fix, rem_fix, final_res;
    logic [2*XLEN-1:0] prod, prod_fix;
    assign step_acc  = op_q[2] ? div_acc : mul_acc;
    assign step_lo   = op_q[2] ? div_lo  : mul_lo;
    assign prod      = {mul_acc, mul_lo};
    assign prod_fix  = (sign_a_q ^ sign_b_q) ? (~prod + ONE2) : prod;
    assign quo_fix   = (sign_a_q ^ sign_b_q) ? (~div_lo + ONE) : div_lo;
    assign rem_fix   = sign_a_q ? (~div_acc + ONE) : div_acc;
    assign final_res = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                               : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                       : prod_fix[2*XLEN-1:XLEN]);

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        rd_cap_d = rd_cap_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
                if (start) begin
                    op_d     = op;
                    rd_cap_d = rd_in;
                    sign_a_d = sa_in;
                    sign_b_d = sb_in;
                    acc_d    = '0;
                    lo_d     = mag_a;
                    opnd_d   = mag_b;
                    cnt_d    = '0;
                    if (in_div0 || in_ovf) begin
                        state_d  = DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        result_d = special_res;
                        rd_out_d = rd_in;
                    end else begin
                        state_d = BUSY;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
            BUSY: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = final_res;
                    rd_out_d = rd_cap_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over start and completion; the visible result is preserved.
        if (flush) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
            rd_cap_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            rd_cap_q <= rd_cap_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results come from a plain-arithmetic
// RV32M model; a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .rd_in(rd_in), .flush(flush), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_res = 32'd0;
    logic [4:0]  last_rd = 5'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // RV32M reference using 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        case (f)
            3'd0: p = ux * uy;
            3'd1: p = (sx * sy) >>> 32;
            3'd2: p = (sx * uy) >>> 32;
            3'd3: p = (ux * uy) >> 32;
            3'd4: p = (y == 0) ? -1 : ((x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? sx : sx / sy);
            3'd5: p = (y == 0) ? -1 : ux / uy;
            3'd6: p = (y == 0) ? sx : ((x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 0 : sx % sy);
            default: p = (y == 0) ? ux : ux % uy;
        endcase
        return p[31:0];
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn rd=%0d result=%08h expected=%08h", rd_out, result, e.res);
                check("result", {32'd0, result}, {32'd0, e.res});
                check("rd_out", {59'd0, rd_out}, {59'd0, e.rd});
                last_res = e.res;
                last_rd  = e.rd;
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
        exp_t e;
        start = 1'b1;
        op    = f;
        a     = x;
        b     = y;
        rd_in = r;
        e.res = model(f, x, y);
        e.rd  = r;
        exp_q.push_back(e);
    endtask

    // Called just after the capture edge; returns at the negedge of the done cycle.
    task automatic wait_done(input string name, input int exp_lat, input bit drop_start);
        bit seen = 1'b0;
        bit busy_ok = 1'b1;
        int lat = -1;
        for (int i = 0; i <= exp_lat + 4; i++) begin
            @(negedge clk);
            if (drop_start) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy"}, {62'd0, busy_ok, busy & seen}, {62'd0, 1'b1, 1'b0});
    endtask

    task automatic run(input string name, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] r);
        @(negedge clk);
        issue(f, x, y, r);
        @(posedge clk);
        wait_done(name, is_special(f, x, y) ? 0 : 32, 1'b1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int done_cnt;
        // Reset held with start asserted.
        rst = 1'b0; start = 1'b1; op = 3'd4; a = 32'd5; b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", {32'd0, result}, 64'd0);
        check("reset_rd", {59'd0, rd_out}, 64'd0);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        check("release_idle", {62'd0, busy, done}, 64'd0);

        run("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        run("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6);
        run("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
        run("divu",   3'd5, 32'd100, 32'd7, 5'd9);
        run("remu",   3'd7, 32'd100, 32'd7, 5'd10);
        run("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11);
        run("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd12);
        run("div0",   3'd4, 32'd5, 32'd0, 5'd13);
        run("rem0",   3'd6, 32'd5, 32'd0, 5'd14);
        run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);

        // Flush 10 cycles into a MUL: no result expected.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd123; b = 32'd456; rd_in = 5'd20;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        @(negedge clk) flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_done", {63'd0, done}, 64'd0);
        check("flush_result", {32'd0, result}, {32'd0, last_res});
        check("flush_rd", {59'd0, rd_out}, {59'd0, last_rd});
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("flush_no_done", 64'(done_cnt), 64'd0);
        run("divu_after_flush", 3'd5, 32'd9, 32'd3, 5'd21);

        // start held through busy; second op is taken only at the DONE edge.
        @(negedge clk);
        issue(3'd0, 32'd1000, 32'd3000, 5'd22);
        @(posedge clk);
        #1 issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd23);
        wait_done("hold1", 32, 1'b0);
        @(posedge clk);
        wait_done("hold2", 32, 1'b1);

        // Special case captured during DONE keeps done high.
        @(negedge clk);
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd24);
        @(posedge clk);
        wait_done("sd1", 32, 1'b0);
        issue(3'd4, 32'd5, 32'd0, 5'd25);
        @(posedge clk);
        wait_done("sd2", 0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            logic [2:0]  f;
            logic [31:0] x, y;
            f = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            run("rand", f, x, y, 5'($urandom_range(0, 31)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file. It takes the two source operands read out of the register file, together with the destination register index. It computes one of the eight M-extension operations with a shift-add multiplier or a restoring divider at one bit per cycle. It returns a registered result plus the destination index so the writeback path can drive the register file write port.

## Interface
- XLEN, 32: operand/result width; the iteration count equals XLEN.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand (register file RD1).
- b  in  XLEN  rs2 operand (register file RD2).
- rd_in  in  5  destination register index, captured with start.
- flush  in  1  abort the current operation (pipeline flush).
- busy  out  1  high while iterating (state BUSY).
- done  out  1  one-cycle pulse; result and rd_out valid.
- result  out  XLEN  operation result; holds until the next done.
- rd_out  out  5  captured rd_in; holds with result.

## Operation
- States: IDLE, BUSY, DONE. Reset (rst=0 at an edge) forces IDLE, busy=0, done=0, result=0, rd_out=0, counter=0, and clears internal registers.
- Start acceptance:
  - IDLE or DONE with start=1 and flush=0 captures op, rd_in, a and b.
  - DONE with start=0 goes to IDLE.
  - start in BUSY is ignored. The issuer must hold the instruction while busy=1.
- Capture step:
  - Record the operand signs (MULH: both signed; MULHSU: a only; DIV/REM: both; others unsigned).
  - Load magnitudes: a negative signed operand is replaced by its two's complement.
  - Clear the counter and go to BUSY.
- Special cases, decided at capture and going straight to DONE:
  - Divide by zero (b=0, any of DIV/DIVU/REM/REMU): quotient = all ones, remainder = a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Multiply:
  - 2*XLEN product register; each BUSY cycle adds the multiplicand when the current multiplier LSB is 1, then shifts right.
  - After XLEN iterations, negate the 64-bit product if the recorded signs differ.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide:
  - Restoring algorithm. Each cycle shift {rem,quo} left by 1 and trial-subtract the divisor. If the difference is non-negative, keep it and set quo LSB=1.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a). Both are applied only for DIV/REM.
- Sign correction and selection of result/rd_out happen on the BUSY→DONE edge (counter = XLEN-1).
- flush=1 at any edge: go to IDLE, busy=0, done=0. result and rd_out keep their previous values. flush has priority over start in the same cycle. rst has priority over flush.
- rd_in=0 is computed normally. The register file discards writes to x0.

## Timing
- Start captured at edge E0.
- Normal operations:
  - busy=1 from after E0 through E32, i.e. 32 cycles.
  - done=1 for exactly the cycle after E32.
- Special cases: done=1 in the cycle immediately after E0, and busy stays 0.
- Back-to-back: start=1 during the DONE cycle is captured at that edge. done then drops and busy rises on the next cycle.
- done is never high for two consecutive cycles, except when a special case is captured during DONE; in that case done stays high with the new result.
- result and rd_out change only on the edge that enters DONE, on reset, or never otherwise.

## Test plan
- Reset:
  - Hold rst=0 for 2 cycles with start=1 → busy=0, done=0, result=0, rd_out=0.
  - Release rst → IDLE, no done.
- Multiply:
  - MUL a=7, b=0xFFFFFFFD (−3), rd_in=5 → done exactly 33 cycles after the start edge, result=0xFFFFFFEB, rd_out=5.
  - MULH a=b=0x80000000 → result 0x40000000.
  - MULHU a=b=0xFFFFFFFF → result 0xFFFFFFFE.
- Divide:
  - DIVU 100/7 → result 14.
  - REMU 100/7 → result 2.
  - REM a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFF.
  - DIV −7/2 → 0xFFFFFFFD.
- Special cases:
  - DIV a=5, b=0 → done 1 cycle after start, result 0xFFFFFFFF.
  - REM a=5, b=0 → result 5.
  - DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000.
  - REM with the same operands → result 0.
- Flush:
  - Flush asserted 10 cycles into a MUL → busy=0 next cycle, no done pulse, result unchanged.
  - A new DIVU 9/3 issued right after completes with result 3.
- Handshake:
  - start held high during busy for a second op → second op ignored until DONE.
  - Back-to-back start in DONE → second result correct, busy rises the cycle after done.
